exhaustive_stim_capture: RTL and testbench
==========================================

// Module: exhaustive_stim_capture
// PURPOSE
//  Synthesizable exhaustive-stimulus engine for trojan-detection benches.
//  Drives all 2^N_IN input patterns into a DUT, sampling each response after a
//  programmable settle time. Compacts all responses into a MISR signature.
//  Sits between a bench/controller and the DUT under test.
//  Replaces fixed-width, hand-written pattern sweeps.
// PARAMETERS
//  N_IN       4        DUT input width; the sweep covers 2^N_IN patterns (1..16)
//  N_OUT      1        DUT output width; N_OUT <= SIG_W
//  SETTLE_CYC 1        cycles between pattern apply and response sample (0..255)
//  SIG_W      16       MISR signature width
//  POLY       16'h1021 MISR feedback polynomial (SIG_W bits)
// PORTS
//  CK            in   1        clock, rising edge
//  reset         in   1        asynchronous, active-high reset
//  start         in   1        begin sweep; honoured only in IDLE
//  gray_mode     in   1        0 = binary order, 1 = Gray-code order; latched at start
//  dut_in        out  N_IN     pattern driven to the DUT
//  dut_out       in   N_OUT    DUT response
//  busy          out  1        high from APPLY through the last SAMPLE
//  sample_valid  out  1        1-cycle strobe in each SAMPLE cycle
//  sample_data   out  N_OUT    dut_out captured in that SAMPLE cycle
//  pattern_count out  N_IN+1   number of patterns sampled so far
//  signature     out  SIG_W    MISR state; held after done
//  done          out  1        1-cycle pulse after the last sample
// BEHAVIOUR
//  - reset (async, active-high): state = IDLE.
//    All outputs are 0: dut_in, busy, sample_valid, sample_data, pattern_count,
//    signature, done. The internal counter is also 0.
//  - FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
//  - IDLE -> APPLY on start.
//    * Clears signature, pattern_count and cnt to 0.
//    * Latches gray_mode.
//  - APPLY (1 cycle): dut_in = binary mode ? cnt : cnt ^ (cnt >> 1).
//    Goes to SETTLE if SETTLE_CYC > 0, else directly to SAMPLE.
//  - SETTLE: stays SETTLE_CYC cycles; dut_in is held stable.
//  - SAMPLE (1 cycle):
//    * sample_valid = 1 and sample_data = dut_out.
//    * sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zext(dut_out).
//    * pattern_count increments.
//    * If cnt == 2^N_IN - 1 -> DONE. Else cnt increments -> APPLY.
//  - Cost per pattern = SETTLE_CYC + 2 cycles.
//  - DONE (1 cycle): done = 1, busy = 0 -> IDLE.
//    signature and pattern_count hold until the next start.
//    dut_in holds the last pattern.
//  - start while busy or in DONE is ignored. No queued restart.
//  - gray_mode changes mid-sweep have no effect.
//  - cnt is N_IN bits; termination is by compare, never by wrap.
//    pattern_count reaches exactly 2^N_IN.
//  - reset mid-sweep: immediate IDLE with all outputs 0. No partial done.
// CONFIGURATION
//  - Macro GOLDEN_CHECK_EN.
//  - When defined:
//    * adds input golden_sig [SIG_W] and output mismatch [1].
//    * On entry to DONE, mismatch <= (signature_final != golden_sig).
//    * mismatch holds until the next start (cleared) or reset (0).
//  - When undefined: neither port exists and there is no compare logic.
// STRUCTURE
//  - Package esc_pkg:
//    * typedef enum esc_state_t {IDLE, APPLY, SETTLE, SAMPLE, DONE}
//    * localparam MISR_POLY_16 = 16'h1021
//    * function bin2gray
//  - Sub-module misr_compactor #(SIG_W, N_IN_W = N_OUT, POLY):
//    * ports: CK, reset, clr, en, din, sig.
//    * Top keeps the FSM, counter and settle timer.
// TESTING
//  1. N_IN=4, SETTLE_CYC=1, binary, dut_out = ^dut_in; start at cycle 0.
//     -> 16 sample_valid strobes.
//     -> sample_data = 0,1,1,0,1,0,0,1,...
//     -> done 49 cycles after start; pattern_count = 16.
//  2. dut_out tied to 0, any mode.
//     -> signature = 0 at done.
//     -> every sample_data = 0.
//  3. gray_mode = 1.
//     -> dut_in sequence 0,1,3,2,6,7,5,4,12,...,8.
//     -> exactly one bit changes between consecutive APPLYs.
//  4. SETTLE_CYC = 0.
//     -> 2 cycles per pattern; done 33 cycles after start.
//     -> Pulse start at cycle 5 -> ignored; single done.
//  5. Assert reset at pattern 7 during SETTLE.
//     -> all outputs 0 asynchronously.
//     -> A new start restarts at dut_in = 0 with pattern_count = 0.
//  6. GOLDEN_CHECK_EN, dut_out = 0: golden_sig = 0 -> mismatch = 0.
//     Same run with golden_sig = 16'h0001 -> mismatch = 1, set with done.

Source files
------------

// File: rtl/esc_pkg.sv
// Shared types and helpers for the exhaustive stimulus capture engine.
package esc_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      APPLY  = 3'd1,
      SETTLE = 3'd2,
      SAMPLE = 3'd3,
      DONE   = 3'd4
   } esc_state_t;

   localparam logic [15:0] MISR_POLY_16 = 16'h1021;

   // Binary to reflected Gray code; callers truncate to their own width.
   function automatic logic [15:0] bin2gray(input logic [15:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/misr_compactor.sv
// Multiple-input signature register: shift left, fold the MSB back through
// POLY, and XOR in the zero-extended response word.
module misr_compactor
   import esc_pkg::*;
#(
   parameter int               SIG_W  = 16,
   parameter int               N_IN_W = 1,
   parameter logic [SIG_W-1:0] POLY   = SIG_W'(MISR_POLY_16)
) (
   input  logic              CK,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   input  logic [N_IN_W-1:0] din,
   output logic [SIG_W-1:0]  sig
);

   logic [SIG_W-1:0] r_sig;
   logic [SIG_W-1:0] w_sig_next;

   // Next signature value from the current state and the incoming response.
   always_comb begin
      w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                 ^ (r_sig[SIG_W-1] ? POLY : '0)
                 ^ SIG_W'(din);
   end

   // Signature register: clear has priority over compaction.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CK or posedge reset) begin
      if (reset)      r_sig <= '0;
      else if (clr)   r_sig <= '0;
      else if (en)    r_sig <= w_sig_next;
   end

   assign sig = r_sig;

endmodule

// File: rtl/exhaustive_stim_capture.sv
// Exhaustive stimulus engine: sweeps all 2^N_IN patterns (binary or Gray
// order) into a DUT, samples each response after SETTLE_CYC cycles and
// compacts the responses into a MISR signature.
// Optional feature: define GOLDEN_CHECK_EN to add golden_sig / mismatch.
module exhaustive_stim_capture
   import esc_pkg::*;
#(
   parameter int               N_IN       = 4,
   parameter int               N_OUT      = 1,
   parameter int               SETTLE_CYC = 1,
   parameter int               SIG_W      = 16,
   parameter logic [SIG_W-1:0] POLY       = SIG_W'(MISR_POLY_16)
) (
   input  logic              CK,
   input  logic              reset,
   input  logic              start,
   input  logic              gray_mode,
   output logic [N_IN-1:0]   dut_in,
   input  logic [N_OUT-1:0]  dut_out,
   output logic              busy,
   output logic              sample_valid,
   output logic [N_OUT-1:0]  sample_data,
   output logic [N_IN:0]     pattern_count,
   output logic [SIG_W-1:0]  signature,
   output logic              done
`ifdef GOLDEN_CHECK_EN
   ,
   input  logic [SIG_W-1:0]  golden_sig,
   output logic              mismatch
`endif
);

   localparam bit       HAS_SETTLE  = (SETTLE_CYC > 0);
   localparam logic [7:0] SETTLE_LAST = 8'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

   esc_state_t        r_state, w_next_state;
   logic [N_IN-1:0]   r_cnt;
   logic [N_IN-1:0]   r_dut_in;
   logic [N_IN:0]     r_pattern_count;
   logic [7:0]        r_settle;
   logic              r_gray;

   logic              w_start_ok;
   logic              w_last;
   logic [N_IN-1:0]   w_cnt_inc;
   logic [15:0]       w_gray_full;
   logic [N_IN-1:0]   w_next_pat;

   assign w_start_ok  = (r_state == IDLE) && start;
   assign w_last      = (r_cnt == {N_IN{1'b1}});
   assign w_cnt_inc   = r_cnt + 1'b1;
   assign w_gray_full = bin2gray(16'(w_cnt_inc));
   assign w_next_pat  = r_gray ? w_gray_full[N_IN-1:0] : w_cnt_inc;

   // State register.
   always_ff @(posedge CK or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state logic.
   // NOTE: the default assignment first keeps this block free of latches.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (start) w_next_state = APPLY;
         APPLY:   w_next_state = HAS_SETTLE ? SETTLE : SAMPLE;
         SETTLE:  if (r_settle == SETTLE_LAST) w_next_state = SAMPLE;
         SAMPLE:  w_next_state = w_last ? DONE : APPLY;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Counter, settle timer, pattern register and sample counter. The pattern
   // is loaded on entry to APPLY so it is already on dut_in during APPLY.
   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         r_cnt           <= '0;
         r_dut_in        <= '0;
         r_pattern_count <= '0;
         r_settle        <= '0;
         r_gray          <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_cnt           <= '0;
                  r_dut_in        <= '0;
                  r_pattern_count <= '0;
                  r_gray          <= gray_mode;
               end
            end
            APPLY:  r_settle <= '0;
            SETTLE: r_settle <= r_settle + 8'd1;
            SAMPLE: begin
               r_pattern_count <= r_pattern_count + 1'b1;
               if (!w_last) begin
                  r_cnt    <= w_cnt_inc;
                  r_dut_in <= w_next_pat;
               end
            end
            default: ;
         endcase
      end
   end

   misr_compactor #(
      .SIG_W  (SIG_W),
      .N_IN_W (N_OUT),
      .POLY   (POLY)
   ) u_misr (
      .CK    (CK),
      .reset (reset),
      .clr   (w_start_ok),
      .en    (r_state == SAMPLE),
      .din   (dut_out),
      .sig   (signature)
   );

`ifdef GOLDEN_CHECK_EN
   logic             r_mismatch;
   logic [SIG_W-1:0] w_sig_final;

   // Signature value that the last SAMPLE commits, compared as DONE is entered.
   always_comb begin
      w_sig_final = {signature[SIG_W-2:0], 1'b0}
                  ^ (signature[SIG_W-1] ? POLY : '0)
                  ^ SIG_W'(dut_out);
   end

   // Golden compare flag: cleared at start, set on entry to DONE.
   always_ff @(posedge CK or posedge reset) begin
      if (reset)                                r_mismatch <= 1'b0;
      else if (w_start_ok)                      r_mismatch <= 1'b0;
      else if ((r_state == SAMPLE) && w_last)   r_mismatch <= (w_sig_final != golden_sig);
   end

   assign mismatch = r_mismatch;
`endif

   assign dut_in        = r_dut_in;
   assign pattern_count = r_pattern_count;
   assign busy          = (r_state == APPLY) || (r_state == SETTLE) || (r_state == SAMPLE);
   assign sample_valid  = (r_state == SAMPLE);
   assign sample_data   = (r_state == SAMPLE) ? dut_out : '0;
   assign done          = (r_state == DONE);

endmodule

// File: tb/tb_exhaustive_stim_capture.sv
// Self-checking bench for exhaustive_stim_capture. Two instances: SETTLE_CYC=1
// (inst A) and SETTLE_CYC=0 (inst B). Responses come from parity, constant
// zero or a random truth table; a sweep-level model predicts the patterns,
// responses, signature and done timing.
module tb_exhaustive_stim_capture;

   localparam int NPAT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_start = 1'b0, b_start = 1'b0;
   logic        gray = 1'b0;
   logic [3:0]  a_dut_in, b_dut_in;
   logic [0:0]  a_out, b_out;
   logic        a_busy, b_busy, a_valid, b_valid, a_done, b_done;
   logic [0:0]  a_sdata, b_sdata;
   logic [4:0]  a_pcnt, b_pcnt;
   logic [15:0] a_sig, b_sig;
`ifdef GOLDEN_CHECK_EN
   logic [15:0] golden = 16'h0;
   logic        a_mis, b_mis, m_mis;
   logic        mis_at_done;
`endif

   int          resp_mode = 0;
   logic [15:0] lut = 16'h0;
   int          errors = 0;
   int          checks = 0;

   logic        sel = 1'b0;
   logic [3:0]  m_dut_in;
   logic        m_busy, m_valid, m_done;
   logic [0:0]  m_sdata;
   logic [4:0]  m_pcnt;
   logic [15:0] m_sig;

   always #5 clk = ~clk;

   always_comb begin
      a_out = (resp_mode == 0) ? ^a_dut_in : (resp_mode == 1) ? 1'b0 : lut[a_dut_in];
      b_out = (resp_mode == 0) ? ^b_dut_in : (resp_mode == 1) ? 1'b0 : lut[b_dut_in];
   end

   exhaustive_stim_capture #(.N_IN(4), .N_OUT(1), .SETTLE_CYC(1), .SIG_W(16)) u_a (
      .CK(clk), .reset(rst), .start(a_start), .gray_mode(gray),
      .dut_in(a_dut_in), .dut_out(a_out), .busy(a_busy), .sample_valid(a_valid),
      .sample_data(a_sdata), .pattern_count(a_pcnt), .signature(a_sig), .done(a_done)
`ifdef GOLDEN_CHECK_EN
      , .golden_sig(golden), .mismatch(a_mis)
`endif
   );

   exhaustive_stim_capture #(.N_IN(4), .N_OUT(1), .SETTLE_CYC(0), .SIG_W(16)) u_b (
      .CK(clk), .reset(rst), .start(b_start), .gray_mode(gray),
      .dut_in(b_dut_in), .dut_out(b_out), .busy(b_busy), .sample_valid(b_valid),
      .sample_data(b_sdata), .pattern_count(b_pcnt), .signature(b_sig), .done(b_done)
`ifdef GOLDEN_CHECK_EN
      , .golden_sig(golden), .mismatch(b_mis)
`endif
   );

   assign m_dut_in = sel ? b_dut_in : a_dut_in;
   assign m_busy   = sel ? b_busy   : a_busy;
   assign m_valid  = sel ? b_valid  : a_valid;
   assign m_done   = sel ? b_done   : a_done;
   assign m_sdata  = sel ? b_sdata  : a_sdata;
   assign m_pcnt   = sel ? b_pcnt   : a_pcnt;
   assign m_sig    = sel ? b_sig    : a_sig;
`ifdef GOLDEN_CHECK_EN
   assign m_mis    = sel ? b_mis    : a_mis;
`endif

   function automatic logic resp_of(input logic [3:0] p);
      case (resp_mode)
         0:       return ^p;
         1:       return 1'b0;
         default: return lut[p];
      endcase
   endfunction

   task automatic check_all_zero(input string tag);
      logic [31:0] agg;
      agg = {a_dut_in, a_busy, a_valid, a_sdata, a_pcnt, a_sig, a_done};
      checks++;
      if (agg !== 32'h0) begin
         errors++;
         $display("FAIL %s_a: outputs=%08h expected 00000000", tag, agg);
      end
      agg = {b_dut_in, b_busy, b_valid, b_sdata, b_pcnt, b_sig, b_done};
      checks++;
      if (agg !== 32'h0) begin
         errors++;
         $display("FAIL %s_b: outputs=%08h expected 00000000", tag, agg);
      end
   endtask

   // One full sweep. inject: 0 none, 1 start pulse at cycle 5, 2 start during DONE.
   task automatic run_sweep(input bit use_b, input logic g, input int inject, input bit flip_gray);
      logic [3:0]  pat [NPAT];
      logic        rsp [NPAT];
      logic [15:0] esig;
      logic [3:0]  prev;
      int          settle, exp_done, k, ndone, done_cyc, busy_after;
      settle   = use_b ? 0 : 1;
      exp_done = 1 + NPAT * (settle + 2);
      esig     = 16'h0;
      for (int i = 0; i < NPAT; i++) begin
         pat[i] = g ? 4'(i ^ (i >> 1)) : 4'(i);
         rsp[i] = resp_of(pat[i]);
         esig   = {esig[14:0], 1'b0} ^ (esig[15] ? 16'h1021 : 16'h0) ^ {15'h0, rsp[i]};
      end
      sel = use_b;
      @(negedge clk);
      gray = g;
      if (use_b) b_start = 1'b1; else a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0; b_start = 1'b0;
      k = 0; ndone = 0; done_cyc = -1; busy_after = 0; prev = 4'h0;
      for (int cyc = 1; cyc <= exp_done + 6; cyc++) begin
         if (flip_gray && cyc == 1) gray = ~g;
         if (inject == 1 && cyc == 5) begin a_start = !use_b; b_start = use_b; end
         if (inject == 1 && cyc == 6) begin a_start = 1'b0; b_start = 1'b0; end
         if (cyc == 1) begin
            checks++;
            if ({m_busy, m_dut_in, m_pcnt} !== {1'b1, pat[0], 5'd0}) begin
               errors++;
               $display("FAIL first_apply: busy/dut_in/count=%0h/%0h/%0d expected 1/%0h/0",
                        m_busy, m_dut_in, m_pcnt, pat[0]);
            end
         end
         if (m_valid) begin
            if (k < NPAT) begin
               checks++;
               if (m_dut_in !== pat[k]) begin
                  errors++;
                  $display("FAIL dut_in[%0d]: got %0h expected %0h", k, m_dut_in, pat[k]);
               end
               checks++;
               if (m_sdata !== rsp[k]) begin
                  errors++;
                  $display("FAIL sample_data[%0d]: got %0h expected %0h", k, m_sdata, rsp[k]);
               end
               checks++;
               if (m_pcnt !== 5'(k) || m_busy !== 1'b1) begin
                  errors++;
                  $display("FAIL count_busy[%0d]: count=%0d busy=%0b expected %0d 1",
                           k, m_pcnt, m_busy, k);
               end
               if (g && k > 0) begin
                  checks++;
                  if ($countones(m_dut_in ^ prev) != 1) begin
                     errors++;
                     $display("FAIL gray_step[%0d]: %0h -> %0h changes %0d bits expected 1",
                              k, prev, m_dut_in, $countones(m_dut_in ^ prev));
                  end
               end
            end
            prev = m_dut_in;
            k++;
         end
         if (m_done) begin
            ndone++;
            if (ndone == 1) begin
               done_cyc = cyc;
               if (inject == 2) begin a_start = !use_b; b_start = use_b; end
               checks++;
               if (cyc != exp_done) begin
                  errors++;
                  $display("FAIL done_time: cycle %0d expected %0d", cyc, exp_done);
               end
               checks++;
               if (m_sig !== esig || m_pcnt !== 5'd16 || m_busy !== 1'b0) begin
                  errors++;
                  $display("FAIL done_state: sig=%04h count=%0d busy=%0b expected %04h 16 0",
                           m_sig, m_pcnt, m_busy, esig);
               end
`ifdef GOLDEN_CHECK_EN
               mis_at_done = m_mis;
`endif
            end
         end else if (done_cyc > 0) begin
            a_start = 1'b0; b_start = 1'b0;
            if (m_busy) busy_after++;
         end
         @(negedge clk);
      end
      a_start = 1'b0; b_start = 1'b0;
      checks++;
      if (ndone != 1 || k != NPAT || busy_after != 0) begin
         errors++;
         $display("FAIL sweep_summary: done_pulses=%0d samples=%0d busy_after_done=%0d expected 1 16 0",
                  ndone, k, busy_after);
      end
      checks++;
      if (m_sig !== esig || m_pcnt !== 5'd16 || m_dut_in !== pat[NPAT-1]) begin
         errors++;
         $display("FAIL hold_after_done: sig=%04h count=%0d dut_in=%0h expected %04h 16 %0h",
                  m_sig, m_pcnt, m_dut_in, esig, pat[NPAT-1]);
      end
   endtask

   task automatic test_reset();
      #2;
      check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("idle_after_reset");
   endtask

   task automatic test_parity_binary();
      resp_mode = 0;
      run_sweep(1'b0, 1'b0, 0, 1'b1);
   endtask

   task automatic test_zero_response();
      resp_mode = 1;
      run_sweep(1'b0, 1'b1, 0, 1'b0);
      run_sweep(1'b1, 1'b0, 0, 1'b0);
   endtask

   task automatic test_gray_random();
      resp_mode = 2;
      lut = 16'($urandom);
      run_sweep(1'b0, 1'b1, 1, 1'b0);
   endtask

   task automatic test_settle_zero();
      resp_mode = 2;
      lut = 16'($urandom);
      run_sweep(1'b1, 1'b0, 1, 1'b0);
      lut = 16'($urandom);
      run_sweep(1'b1, 1'b1, 2, 1'b0);
   endtask

   task automatic test_back_to_back();
      resp_mode = 2;
      for (int n = 0; n < 2; n++) begin
         lut = 16'($urandom);
         run_sweep(1'b0, n[0], 2, 1'b0);
      end
   endtask

   task automatic test_reset_mid_sweep();
      resp_mode = 2;
      lut = 16'($urandom);
      sel = 1'b0;
      @(negedge clk);
      gray = 1'b0;
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      // cycle 1 observed here; pattern 7 SETTLE is cycle 1 + 7*3 + 1 = 23
      repeat (22) @(negedge clk);
      checks++;
      if (a_dut_in !== 4'd7 || a_busy !== 1'b1 || a_valid !== 1'b0) begin
         errors++;
         $display("FAIL pre_reset_settle: dut_in=%0h busy=%0b valid=%0b expected 7 1 0",
                  a_dut_in, a_busy, a_valid);
      end
      rst = 1'b1;
      #1;
      check_all_zero("async_reset_mid");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("after_mid_reset");
      run_sweep(1'b0, 1'b0, 0, 1'b0);
   endtask

`ifdef GOLDEN_CHECK_EN
   task automatic test_golden();
      resp_mode = 1;
      golden = 16'h0000;
      run_sweep(1'b0, 1'b0, 0, 1'b0);
      checks++;
      if (mis_at_done !== 1'b0) begin
         errors++;
         $display("FAIL golden_match: mismatch=%0b expected 0", mis_at_done);
      end
      golden = 16'h0001;
      run_sweep(1'b0, 1'b0, 0, 1'b0);
      checks++;
      if (mis_at_done !== 1'b1) begin
         errors++;
         $display("FAIL golden_diff: mismatch=%0b expected 1", mis_at_done);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_parity_binary();
      test_zero_response();
      test_gray_random();
      test_settle_zero();
      test_back_to_back();
      test_reset_mid_sweep();
`ifdef GOLDEN_CHECK_EN
      test_golden();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
